// File: rtl/bus_bridge_pkg.sv
// Shared bus constants and access-size codes for bus_bridge.
// Default widths mirror femto.vh; an earlier inclusion of femto.vh takes precedence.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif
`ifndef BRIDGE_SIZE
`define BRIDGE_SIZE 4096
`endif

package bus_bridge_pkg;

  localparam int XLEN_W = `XLEN;
  localparam int BUS_W  = `BUS_WIDTH;
  localparam int ACC_W  = $clog2(`BUS_ACC_CNT);

  typedef enum logic [ACC_W-1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2
  } acc_e;

  // Keep only the low 'span' address bits: the peripheral sees a window-local offset.
  function automatic logic [XLEN_W-1:0] span_addr(input logic [XLEN_W-1:0] addr,
                                                 input int span);
    logic [XLEN_W-1:0] keep;
    keep = '0;
    for (int i = 0; i < XLEN_W; i++) begin
      if (i < span) keep[i] = 1'b1;
      else          keep[i] = 1'b0;
    end
    return addr & keep;
  endfunction

endpackage

// File: rtl/bus_bridge.sv
// Single-outstanding bridge from the data-bus interconnect to a peripheral bus.
// Optional feature: define BRIDGE_TIMEOUT_EN to bound the peripheral wait with TIMEOUT_CYCLES.
module bus_bridge
  import bus_bridge_pkg::*;
#(
  parameter int BRIDGE_SPAN    = $clog2(`BRIDGE_SIZE),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_req,
  input  logic [XLEN_W-1:0] s_addr,
  input  logic              s_w_rb,
  input  logic [ACC_W-1:0]  s_acc,
  input  logic [BUS_W-1:0]  s_wdata,
  output logic              s_resp,
  output logic [BUS_W-1:0]  s_rdata,
  output logic              p_req,
  output logic [XLEN_W-1:0] p_addr,
  output logic              p_w_rb,
  output logic [ACC_W-1:0]  p_acc,
  output logic [BUS_W-1:0]  p_wdata,
  input  logic              p_resp,
  input  logic [BUS_W-1:0]  p_rdata,
  output logic              busy,
  output logic              bridge_fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e state_r;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_r;
`endif

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      s_resp       <= 1'b0;
      s_rdata      <= '0;
      p_req        <= 1'b0;
      p_addr       <= '0;
      p_w_rb       <= 1'b0;
      p_acc        <= '0;
      p_wdata      <= '0;
      busy         <= 1'b0;
      bridge_fault <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      to_cnt_r     <= '0;
`endif
    end else begin
      s_resp       <= 1'b0;
      p_req        <= 1'b0;
      // A request arriving while a transaction is outstanding is dropped and flagged.
      bridge_fault <= s_req & busy;
      case (state_r)
        ST_IDLE: begin
          if (s_req) begin
            p_addr  <= span_addr(s_addr, BRIDGE_SPAN);
            p_w_rb  <= s_w_rb;
            p_acc   <= s_acc;
            p_wdata <= s_wdata;
            p_req   <= 1'b1;
            busy    <= 1'b1;
            state_r <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // A zero-wait peripheral may answer in the same cycle as p_req.
          if (p_resp) begin
            s_rdata <= p_rdata;
            s_resp  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
`ifdef BRIDGE_TIMEOUT_EN
            to_cnt_r <= '0;
`endif
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (p_resp) begin
            s_rdata <= p_rdata;
            s_resp  <= 1'b1;
            state_r <= ST_DONE;
`ifdef BRIDGE_TIMEOUT_EN
          end else if (to_cnt_r == TO_LIMIT) begin
            s_rdata      <= '0;
            s_resp       <= 1'b1;
            bridge_fault <= 1'b1;
            state_r      <= ST_DONE;
          end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            state_r  <= ST_WAIT;
`else
          end else begin
            state_r <= ST_WAIT;
`endif
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
